// File: rtl/jt08_adpcm_rdiv.sv
// Restoring serial fractional divider: q = floor(n * 2^DW / a), one quotient bit per cen cycle.
// Define JT08_ADPCM_RDIV_ROUND_EN to add a guard iteration that rounds to nearest (ties up).
module jt08_adpcm_rdiv #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          start,
  input  logic [DW-1:0] n,
  input  logic [DW-1:0] a,
  output logic [DW-1:0] q,
  output logic          working,
  output logic          done,
  output logic          ovf
);

`ifdef JT08_ADPCM_RDIV_ROUND_EN
  localparam int ITER = DW + 1;
`else
  localparam int ITER = DW;
`endif
  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] ITER_C = CW'(ITER);

  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] div_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] q_q, q_shift_d, q_last_d;
  logic          working_q, done_q, ovf_q;
  logic [DW:0]   t_d;
  logic          ge_d;
  logic          last_d;

`ifdef JT08_ADPCM_RDIV_ROUND_EN
  // Adds the guard bit to the truncated quotient without wrapping past all ones.
  function automatic logic [DW-1:0] round_sat(input logic [DW-1:0] qt, input logic g);
    logic [DW:0] s;
    s = {1'b0, qt} + {{DW{1'b0}}, g};
    return s[DW] ? '1 : s[DW-1:0];
  endfunction
`endif

  always_comb begin
    t_d       = {rem_q, 1'b0};
    ge_d      = (t_d >= {1'b0, div_q});
    rem_d     = ge_d ? DW'(t_d - {1'b0, div_q}) : t_d[DW-1:0];
    last_d    = (cnt_q == CW'(1));
    q_shift_d = {q_q[DW-2:0], ge_d};
`ifdef JT08_ADPCM_RDIV_ROUND_EN
    q_last_d  = round_sat(q_q, ge_d);
`else
    q_last_d  = q_shift_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      q_q       <= '0;
      working_q <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (cen) begin
      if (start) begin
        // Quotient would not fit a pure fraction: saturate immediately.
        if (a == '0 || n >= a) begin
          q_q       <= '1;
          ovf_q     <= 1'b1;
          done_q    <= 1'b1;
          working_q <= 1'b0;
        end else begin
          rem_q     <= n;
          div_q     <= a;
          q_q       <= '0;
          cnt_q     <= ITER_C;
          ovf_q     <= 1'b0;
          done_q    <= 1'b0;
          working_q <= 1'b1;
        end
      end else if (working_q) begin
        rem_q <= rem_d;
        cnt_q <= cnt_q - CW'(1);
        q_q   <= last_d ? q_last_d : q_shift_d;
        if (last_d) begin
          working_q <= 1'b0;
          done_q    <= 1'b1;
        end
      end
    end
  end

  assign q       = q_q;
  assign working = working_q;
  assign done    = done_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_jt08_adpcm_rdiv.sv
// Directed bench for jt08_adpcm_rdiv (DW=16), covering truncating and rounding builds.
module tb_jt08_adpcm_rdiv;

  localparam int DW = 16;
`ifdef JT08_ADPCM_RDIV_ROUND_EN
  localparam int LAT = DW + 1;
  localparam logic [15:0] EXP_2_3  = 16'hAAAB;
  localparam logic [15:0] EXP_FFFE = 16'hFFFF;
`else
  localparam int LAT = DW;
  localparam logic [15:0] EXP_2_3  = 16'hAAAA;
  localparam logic [15:0] EXP_FFFE = 16'hFFFE;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cen;
  logic          start;
  logic [DW-1:0] n_i;
  logic [DW-1:0] a_i;
  logic [DW-1:0] q;
  logic          working;
  logic          done;
  logic          ovf;

  int n_checks = 0;
  int n_err    = 0;
  int edges;
  logic saw_work;

  jt08_adpcm_rdiv #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .start(start),
    .n(n_i), .a(a_i), .q(q), .working(working), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one start strobe; returns on the negedge following the start edge.
  task automatic pulse_start(input logic [15:0] nv, input logic [15:0] av);
    @(negedge clk);
    n_i   = nv;
    a_i   = av;
    start = 1'b1;
    cen   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_i   = 16'hDEAD;
    a_i   = 16'hBEEF;
  endtask

  // Counts cen-high edges until done rises; mode 1 enables cen one cycle in three.
  task automatic wait_done(input int mode, output int cnt, output logic saw);
    int k;
    k   = 0;
    cnt = 0;
    saw = working;
    while (!done && k < 300) begin
      cen = (mode == 0) ? 1'b1 : (k % 3 == 0);
      @(negedge clk);
      if (cen) cnt++;
      if (working) saw = 1'b1;
      k++;
    end
    cen = 1'b1;
    if (!done) begin
      n_checks++;
      n_err++;
      $error("FAIL timeout: observed done=0 expected done=1 within 300 cycles");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cen   = 1'b0;
    start = 1'b0;
    n_i   = '0;
    a_i   = '0;
    repeat (3) @(negedge clk);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_working", 32'(working), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    rst_n = 1'b1;
    cen   = 1'b1;

    pulse_start(16'h4000, 16'h8000);
    chk("half_working", 32'(working), 32'h1);
    wait_done(0, edges, saw_work);
    chk("half_q", 32'(q), 32'h8000);
    chk("half_ovf", 32'(ovf), 32'h0);
    chk("half_lat", 32'(edges), 32'(LAT));
    chk("half_working_end", 32'(working), 32'h0);

    pulse_start(16'h0001, 16'h0003);
    wait_done(0, edges, saw_work);
    chk("third_q", 32'(q), 32'h5555);

    pulse_start(16'h0002, 16'h0003);
    wait_done(0, edges, saw_work);
    chk("twothird_q", 32'(q), 32'(EXP_2_3));
    chk("twothird_lat", 32'(edges), 32'(LAT));

    // Stall: cen low with start high must change nothing.
    @(negedge clk);
    cen   = 1'b0;
    start = 1'b1;
    n_i   = 16'h0001;
    a_i   = 16'h0002;
    repeat (4) @(negedge clk);
    start = 1'b0;
    chk("stall_q", 32'(q), 32'(EXP_2_3));
    chk("stall_done", 32'(done), 32'h1);
    chk("stall_working", 32'(working), 32'h0);
    cen = 1'b1;

    pulse_start(16'h9000, 16'h8000);
    chk("ovf_big_q", 32'(q), 32'hFFFF);
    chk("ovf_big_ovf", 32'(ovf), 32'h1);
    chk("ovf_big_done", 32'(done), 32'h1);
    chk("ovf_big_working", 32'(working), 32'h0);
    repeat (3) @(negedge clk);
    chk("ovf_big_hold_working", 32'(working), 32'h0);

    pulse_start(16'h0005, 16'h0000);
    chk("ovf_zero_q", 32'(q), 32'hFFFF);
    chk("ovf_zero_ovf", 32'(ovf), 32'h1);
    chk("ovf_zero_working", 32'(working), 32'h0);

    pulse_start(16'hFFFE, 16'hFFFF);
    chk("near1_working", 32'(working), 32'h1);
    chk("near1_ovf_clr", 32'(ovf), 32'h0);
    wait_done(0, edges, saw_work);
    chk("near1_q", 32'(q), 32'(EXP_FFFE));
    chk("near1_ovf", 32'(ovf), 32'h0);

    pulse_start(16'h0002, 16'h0003);
    wait_done(1, edges, saw_work);
    chk("cen3_q", 32'(q), 32'(EXP_2_3));
    chk("cen3_lat", 32'(edges), 32'(LAT));

    // Restart mid-operation: second operands win.
    pulse_start(16'h1234, 16'h5678);
    repeat (6) @(negedge clk);
    chk("abort_done_low", 32'(done), 32'h0);
    pulse_start(16'h0001, 16'h0002);
    wait_done(0, edges, saw_work);
    chk("restart_q", 32'(q), 32'h8000);
    chk("restart_lat", 32'(edges), 32'(LAT));

    // Asynchronous reset in the middle of a division.
    pulse_start(16'h0001, 16'h0003);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q", 32'(q), 32'h0);
    chk("arst_working", 32'(working), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    chk("arst_ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_done", 32'(done), 32'h0);
    chk("post_rst_working", 32'(working), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
